// File: rtl/myproc_pkg.sv
// rtl/myproc_pkg.sv - opcodes, instruction field positions and decode helpers
package myproc_pkg;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RC_MSB = 11;
    localparam int RC_LSB = 8;
    localparam int RA_MSB = 7;
    localparam int RA_LSB = 4;
    localparam int RB_MSB = 3;
    localparam int RB_LSB = 0;
    localparam int IMM_MSB = 7;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic reads_a(input logic [3:0] op);
        return ((op >= OP_ADD) && (op <= OP_XOR)) || (op == OP_MOV);
    endfunction

    function automatic logic reads_b(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic writes_rc(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

    // Everything between MOV and HALT is unassigned.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op > OP_MOV) && (op < OP_HALT);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - 16-entry register busy scoreboard with three hazard lookups
module reg_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_en,
    input  logic [3:0]  set_idx,
    input  logic        clr_en,
    input  logic [3:0]  clr_idx,
    input  logic [3:0]  chk_a,
    input  logic [3:0]  chk_b,
    input  logic [3:0]  chk_c,
    output logic        hit_a,
    output logic        hit_b,
    output logic        hit_c,
    output logic [15:0] busy
);

    logic [15:0] busy_q, busy_d;

    // Set is applied after clear; the issue stage never sets a bit that is still busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign hit_a = busy_q[chk_a];
    assign hit_b = busy_q[chk_b];
    assign hit_c = busy_q[chk_c];
    assign busy  = busy_q;

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode/issue stage: handshake, hazard stall, halt FSM, issue register
module decode_issue
    import myproc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic [3:0]  rf_ra,
    output logic [3:0]  rf_rb,
    output logic        rf_ren,
    input  logic        wb_en,
    input  logic [3:0]  wb_rc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [3:0]  out_rc,
    output logic [15:0] out_imm,
    output logic [15:0] sb_busy,
    output logic        illegal,
    output logic        halted,
    output logic [15:0] issue_cnt
);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  out_op_q, out_op_d;
    logic [3:0]  out_rc_q, out_rc_d;
    logic [7:0]  out_imm_q, out_imm_d;
    logic        illegal_q, illegal_d;
    logic [15:0] issue_cnt_q, issue_cnt_d;

    logic [3:0] op, rc;
    logic       hit_a, hit_b, hit_c, hazard, accept, issue;

    assign op    = in_instr[OP_MSB:OP_LSB];
    assign rc    = in_instr[RC_MSB:RC_LSB];
    assign rf_ra = in_instr[RA_MSB:RA_LSB];
    assign rf_rb = in_instr[RB_MSB:RB_LSB];

    reg_scoreboard u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (issue),
        .set_idx (rc),
        .clr_en  (wb_en),
        .clr_idx (wb_rc),
        .chk_a   (rf_ra),
        .chk_b   (rf_rb),
        .chk_c   (rc),
        .hit_a   (hit_a),
        .hit_b   (hit_b),
        .hit_c   (hit_c),
        .busy    (sb_busy)
    );

    // Only fields the opcode really uses may stall it.
    assign hazard   = (reads_a(op) & hit_a) | (reads_b(op) & hit_b) | (writes_rc(op) & hit_c);
    assign in_ready = (state_q == ST_RUN) & (~out_valid_q | out_ready) & ~hazard;
    assign accept   = in_valid & in_ready;
    assign issue    = accept & writes_rc(op);
    assign rf_ren   = issue;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_rc_d    = out_rc_q;
        out_imm_d   = out_imm_q;
        illegal_d   = accept & is_illegal(op);
        issue_cnt_d = issue_cnt_q;
        if (state_q == ST_RUN && accept && op == OP_HALT) state_d = ST_HALTED;
        if (issue) begin
            out_valid_d = 1'b1;
            out_op_d    = op;
            out_rc_d    = rc;
            out_imm_d   = in_instr[IMM_MSB:0];
            issue_cnt_d = issue_cnt_q + 16'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_rc_q    <= '0;
            out_imm_q   <= '0;
            illegal_q   <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_rc_q    <= out_rc_d;
            out_imm_q   <= out_imm_d;
            illegal_q   <= illegal_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_rc    = out_rc_q;
    assign out_imm   = {8'h00, out_imm_q};
    assign illegal   = illegal_q;
    assign halted    = (state_q == ST_HALTED);
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - randomized and directed bench for decode_issue against a behavioural model
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = '0;
    logic        in_ready;
    logic [3:0]  rf_ra, rf_rb;
    logic        rf_ren;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_rc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_op, out_rc;
    logic [15:0] out_imm, sb_busy;
    logic        illegal, halted;
    logic [15:0] issue_cnt;

    decode_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_ren    (rf_ren),
        .wb_en     (wb_en),
        .wb_rc     (wb_rc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_rc    (out_rc),
        .out_imm   (out_imm),
        .sb_busy   (sb_busy),
        .illegal   (illegal),
        .halted    (halted),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: architectural view of the stage.
    bit       m_busy [16];
    bit       m_halted;
    bit       m_ov;
    bit       m_ill;
    bit [3:0] m_op, m_rc;
    bit [7:0] m_imm;
    int       m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] busy_vec();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
        m_halted = 0; m_ov = 0; m_ill = 0; m_op = 0; m_rc = 0; m_imm = 0; m_cnt = 0;
    endtask

    task automatic check_state();
        check("out_valid", out_valid, m_ov);
        check("out_op", out_op, m_op);
        check("out_rc", out_rc, m_rc);
        check("out_imm", out_imm, {8'h00, m_imm});
        check("sb_busy", sb_busy, busy_vec());
        check("illegal", illegal, m_ill);
        check("halted", halted, m_halted);
        check("issue_cnt", issue_cnt, m_cnt[15:0]);
    endtask

    task automatic step(input logic iv, input logic [15:0] ins, input logic ordy,
                        input logic wbe, input logic [3:0] wbr);
        logic [3:0] op, rc, ra, rb;
        bit haz, rdy, acc;
        @(negedge clk);
        in_valid = iv; in_instr = ins; out_ready = ordy; wb_en = wbe; wb_rc = wbr;
        #1;
        op = ins[15:12]; rc = ins[11:8]; ra = ins[7:4]; rb = ins[3:0];
        haz = (op inside {[1:5], 7} && m_busy[ra]) || (op inside {[1:5]} && m_busy[rb])
              || (op inside {[1:7]} && m_busy[rc]);
        rdy = !m_halted && (!m_ov || ordy) && !haz;
        acc = iv && rdy;
        check("in_ready", in_ready, rdy);
        check("rf_ren", rf_ren, acc && (op inside {[1:7]}));
        check("rf_ra", rf_ra, ra);
        check("rf_rb", rf_rb, rb);
        if (wbe) m_busy[wbr] = 1'b0;
        m_ill = acc && (op inside {[8:14]});
        if (acc && (op inside {[1:7]})) begin
            m_ov = 1; m_op = op; m_rc = rc; m_imm = ins[7:0];
            m_busy[rc] = 1'b1;
            m_cnt = (m_cnt + 1) % 65536;
        end else if (ordy) begin
            m_ov = 0;
        end
        if (acc && op == 4'hF) m_halted = 1;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; wb_en = 1'b0;
        #1;
        model_reset();
        check_state();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] ins;
        logic [3:0]  op, wr;
        logic        wbe;

        model_reset();
        do_reset();

        // ADD r3,r1,r2 then dependent SUB r4,r3,r1 waits for writeback of r3
        step(1, 16'h1312, 1, 0, 0);
        check("add_busy", sb_busy, 16'h0008);
        check("add_op", out_op, 4'h1);
        step(1, 16'h2431, 1, 0, 0);
        step(1, 16'h2431, 1, 1, 3);
        step(1, 16'h2431, 1, 0, 0);
        check("sub_busy", sb_busy, 16'h0010);

        // LDI r5 then MOV r5 under WAW
        step(1, 16'h65A7, 1, 1, 4);
        check("ldi_imm", out_imm, 16'h00A7);
        step(1, 16'h7510, 1, 0, 0);
        check("mov_waw_cnt", issue_cnt, 16'd3);

        // Output back-pressure for three cycles, then drain back-to-back
        step(1, 16'h1600, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 16'h1700, 0, 0, 0);
        check("stall_op", out_rc, 4'h6);
        step(1, 16'h1700, 1, 0, 0);
        step(1, 16'h1800, 1, 0, 0);
        check("drain_cnt", issue_cnt, 16'd6);

        // Random traffic, HALT excluded
        for (int n = 0; n < 1500; n++) begin
            op  = 4'($urandom_range(14));
            ins = {op, 12'($urandom)};
            wbe = 1'b0;
            wr  = 4'($urandom_range(15));
            if ($urandom_range(2) == 0) begin
                for (int t = 0; t < 16 && !wbe; t++) begin
                    wr = 4'($urandom_range(15));
                    if (m_busy[wr]) wbe = 1'b1;
                end
            end else if ($urandom_range(15) == 0) begin
                wbe = 1'b1;
            end
            step(1'($urandom_range(4) != 0), ins, 1'($urandom_range(3) != 0), wbe, wr);
        end

        // Illegal pulse, then HALT is sticky
        step(1, 16'h9000, 1, 0, 0);
        check("illegal_pulse", illegal, 1'b1);
        step(0, 16'h0000, 1, 0, 0);
        check("illegal_clear", illegal, 1'b0);
        step(1, 16'hF000, 1, 0, 0);
        check("halt_set", halted, 1'b1);
        for (int i = 0; i < 3; i++) step(1, 16'h1000, 1, 0, 0);

        do_reset();
        check("reset_halted", halted, 1'b0);
        step(1, 16'h1312, 1, 0, 0);
        check("post_reset_cnt", issue_cnt, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
